// File: rtl/dtw_decision_unit_pkg.sv
// dtw_pkg: types and constants shared by the DTW word-decision stage.
//   - default score / command widths and the base command code
//   - command codes for the word channels (channel k -> DTW_CMD_BASE + k - 1)
//   - decision FSM state type
package dtw_pkg;

    localparam int DTW_SCORE_W  = 27;
    localparam int DTW_CMD_W    = 4;
    localparam int DTW_CMD_BASE = 4;

    localparam logic [DTW_CMD_W-1:0] CMD_NONE      = 4'd0;
    localparam logic [DTW_CMD_W-1:0] CMD_WORD_NONE = 4'(DTW_CMD_BASE + 0);
    localparam logic [DTW_CMD_W-1:0] CMD_RED       = 4'(DTW_CMD_BASE + 1);
    localparam logic [DTW_CMD_W-1:0] CMD_BLACK     = 4'(DTW_CMD_BASE + 2);
    localparam logic [DTW_CMD_W-1:0] CMD_BLUE      = 4'(DTW_CMD_BASE + 3);
    localparam logic [DTW_CMD_W-1:0] CMD_LEFT      = 4'(DTW_CMD_BASE + 4);
    localparam logic [DTW_CMD_W-1:0] CMD_RIGHT     = 4'(DTW_CMD_BASE + 5);
    localparam logic [DTW_CMD_W-1:0] CMD_GO        = 4'(DTW_CMD_BASE + 6);
    localparam logic [DTW_CMD_W-1:0] CMD_STOP      = 4'(DTW_CMD_BASE + 7);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCAN    = 2'd1,
        EMIT    = 2'd2
    } dtw_state_t;

endpackage

// File: rtl/dtw_decision_unit_train.sv
// dtw_train_decoder: combinational decode of a command code into the
// one-hot train enable of the engine that owns that template.
//   i_sel   : command code being trained (0 = noise template)
//   o_train : one-hot engine select, all zero for codes with no engine
module dtw_train_decoder
    import dtw_pkg::*;
#(
    parameter int NUM_WORDS = 8,
    parameter int CMD_W     = DTW_CMD_W,
    parameter int CMD_BASE  = DTW_CMD_BASE
) (
    input  logic [CMD_W-1:0]   i_sel,
    output logic [NUM_WORDS:0] o_train
);

    always_comb begin
        o_train = '0;
        if (i_sel == '0) begin
            o_train[0] = 1'b1;
        end
        for (int k = 1; k <= NUM_WORDS; k++) begin
            if (int'(i_sel) == CMD_BASE + k - 1) begin
                o_train[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dtw_decision_unit.sv
// dtw_decision_unit: collects the scores of the DTW matching engines and
// picks the best word with one comparator iterated over the channels.
// Channel 0 is the noise template; channels 1..NUM_WORDS are words.
//   clock, reset      : clock, asynchronous active-high reset
//   training_enable   : training mode, overrides decisions
//   training_select   : command code of the template being trained
//   dtw_score         : packed scores, channel c at [c*SCORE_W +: SCORE_W]
//   dtw_done          : per-channel completion (level or pulse)
//   dtw_train         : registered one-hot train enables
//   command           : decided command (0 = none), valid with command_valid
//   command_valid     : one-cycle decision strobe
//   busy              : decision in progress (SCAN, EMIT, strobe cycle)
//   timeout_err       : one-cycle strobe when a round is abandoned
// TIMEOUT must be at least 2.
module dtw_decision_unit
    import dtw_pkg::*;
#(
    parameter int NUM_WORDS = 8,
    parameter int SCORE_W   = DTW_SCORE_W,
    parameter int CMD_W     = DTW_CMD_W,
    parameter int CMD_BASE  = DTW_CMD_BASE,
    parameter int MARGIN    = 0,
    parameter int TIMEOUT   = 1 << 20
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             training_enable,
    input  logic [CMD_W-1:0]                 training_select,
    input  logic [(NUM_WORDS+1)*SCORE_W-1:0] dtw_score,
    input  logic [NUM_WORDS:0]               dtw_done,
    output logic [NUM_WORDS:0]               dtw_train,
    output logic [CMD_W-1:0]                 command,
    output logic                             command_valid,
    output logic                             busy,
    output logic                             timeout_err
);

    localparam int NCH   = NUM_WORDS + 1;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_WORDS);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
    localparam logic [SCORE_W:0]   MARGIN_X = (SCORE_W + 1)'(MARGIN);

    dtw_state_t          r_state;
    dtw_state_t          w_state_nxt;
    logic [NUM_WORDS:0]  r_done;
    logic [SCORE_W-1:0]  r_score [NCH];
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_best_idx;
    logic [SCORE_W-1:0]  r_best;
    logic [NUM_WORDS:0]  r_train;
    logic [CMD_W-1:0]    r_command;
    logic                r_cmd_valid;
    logic                r_timeout_err;

    logic [NUM_WORDS:0]  w_train_dec;
    logic                w_all_done;
    logic                w_partial;
    logic                w_cnt_expired;
    logic [SCORE_W-1:0]  w_cur;
    logic                w_less;
    logic                w_accept;
    logic [CMD_W-1:0]    w_cmd_code;

    dtw_train_decoder #(
        .NUM_WORDS (NUM_WORDS),
        .CMD_W     (CMD_W),
        .CMD_BASE  (CMD_BASE)
    ) u_train_dec (
        .i_sel   (training_select),
        .o_train (w_train_dec)
    );

    assign w_all_done    = &r_done;
    assign w_partial     = (|r_done) && !w_all_done;
    assign w_cnt_expired = (r_state == COLLECT) && w_partial && (r_cnt == CNT_LAST);

    // The one shared comparator, walked across channels by r_idx.
    assign w_cur  = r_score[r_idx];
    assign w_less = w_cur < r_best;

    // One extra bit so best + MARGIN never wraps past the noise score.
    assign w_accept   = ({1'b0, r_best} + MARGIN_X) < {1'b0, r_score[0]};
    assign w_cmd_code = CMD_W'(CMD_BASE + int'(r_best_idx) - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (training_enable) begin
            w_state_nxt = COLLECT;
        end else begin
            case (r_state)
                COLLECT: if (w_all_done)         w_state_nxt = SCAN;
                SCAN:    if (r_idx == IDX_LAST)  w_state_nxt = EMIT;
                EMIT:                            w_state_nxt = COLLECT;
                default:                         w_state_nxt = COLLECT;
            endcase
        end
    end

    // Done latches and round timeout counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_done <= '0;
            r_cnt  <= '0;
        end else if (training_enable || (r_state == EMIT) || w_cnt_expired) begin
            r_done <= '0;
            r_cnt  <= '0;
        end else if (r_state == COLLECT) begin
            r_done <= r_done | dtw_done;
            r_cnt  <= w_partial ? r_cnt + 1'b1 : '0;
        end
    end

    // Scores are captured once per round, on the first done of each channel.
    always_ff @(posedge clock) begin
        for (int c = 0; c < NCH; c++) begin
            if ((r_state == COLLECT) && !training_enable && dtw_done[c] && !r_done[c]) begin
                r_score[c] <= dtw_score[c*SCORE_W +: SCORE_W];
            end
        end
    end

    // Arg-min walk; COLLECT keeps the walk preset for the next SCAN entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx      <= IDX_ONE;
            r_best_idx <= IDX_ONE;
        end else if (r_state == COLLECT) begin
            r_idx      <= IDX_ONE;
            r_best_idx <= IDX_ONE;
        end else if (r_state == SCAN) begin
            r_idx <= r_idx + 1'b1;
            if (w_less) begin
                r_best_idx <= r_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (r_state == COLLECT) begin
            r_best <= '1;
        end else if ((r_state == SCAN) && w_less) begin
            r_best <= w_cur;
        end
    end

    // Output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_train       <= '0;
            r_command     <= '0;
            r_cmd_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_train       <= training_enable ? w_train_dec : '0;
            r_cmd_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
            if (!training_enable) begin
                if (r_state == EMIT) begin
                    r_cmd_valid <= 1'b1;
                    r_command   <= w_accept ? w_cmd_code : CMD_W'(CMD_NONE);
                end
                if (w_cnt_expired) begin
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

    assign dtw_train     = r_train;
    assign command       = r_command;
    assign command_valid = r_cmd_valid;
    assign timeout_err   = r_timeout_err;
    // Held through the strobe cycle so busy covers the whole decision.
    assign busy          = (r_state != COLLECT) || r_cmd_valid;

endmodule

// File: tb/tb_dtw_decision_unit.sv
// tb_dtw_decision_unit: directed bench for dtw_decision_unit.
// Three instances share scores, training and reset: u_dut (defaults),
// u_mar (MARGIN=50) and u_to (TIMEOUT=16), each with its own done vector.
module tb_dtw_decision_unit;

    localparam int NW = 8;
    localparam int SW = 27;
    localparam int CW = 4;
    localparam int NC = NW + 1;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            training_enable = 1'b0;
    logic [CW-1:0]   training_select = '0;
    logic [NC*SW-1:0] dtw_score = '0;
    logic [NW:0]     done_a = '0;
    logic [NW:0]     done_m = '0;
    logic [NW:0]     done_t = '0;

    logic [NW:0]   a_train, m_train, t_train;
    logic [CW-1:0] a_cmd, m_cmd, t_cmd;
    logic          a_valid, m_valid, t_valid;
    logic          a_busy, m_busy, t_busy;
    logic          a_terr, m_terr, t_terr;

    int n_cmp = 0;
    int n_bad = 0;
    int sc [NC];

    always #5 clock = ~clock;

    dtw_decision_unit u_dut (
        .clock(clock), .reset(reset), .training_enable(training_enable),
        .training_select(training_select), .dtw_score(dtw_score), .dtw_done(done_a),
        .dtw_train(a_train), .command(a_cmd), .command_valid(a_valid),
        .busy(a_busy), .timeout_err(a_terr)
    );

    dtw_decision_unit #(.MARGIN(50)) u_mar (
        .clock(clock), .reset(reset), .training_enable(training_enable),
        .training_select(training_select), .dtw_score(dtw_score), .dtw_done(done_m),
        .dtw_train(m_train), .command(m_cmd), .command_valid(m_valid),
        .busy(m_busy), .timeout_err(m_terr)
    );

    dtw_decision_unit #(.TIMEOUT(16)) u_to (
        .clock(clock), .reset(reset), .training_enable(training_enable),
        .training_select(training_select), .dtw_score(dtw_score), .dtw_done(done_t),
        .dtw_train(t_train), .command(t_cmd), .command_valid(t_valid),
        .busy(t_busy), .timeout_err(t_terr)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_scores();
        for (int c = 0; c < NC; c++) dtw_score[c*SW +: SW] = SW'(sc[c]);
    endtask

    task automatic basic_scores();
        sc[0] = 1000; sc[1] = 900; sc[2] = 800; sc[3] = 700; sc[4] = 300;
        sc[5] = 650;  sc[6] = 900; sc[7] = 950; sc[8] = 990;
        apply_scores();
    endtask

    task automatic set_done(input int w, input logic [NW:0] v);
        case (w)
            0:       done_a = v;
            1:       done_m = v;
            default: done_t = v;
        endcase
    endtask

    function automatic logic get_valid(input int w);
        case (w)
            0:       return a_valid;
            1:       return m_valid;
            default: return t_valid;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0:       return a_busy;
            1:       return m_busy;
            default: return t_busy;
        endcase
    endfunction

    function automatic logic [CW-1:0] get_cmd(input int w);
        case (w)
            0:       return a_cmd;
            1:       return m_cmd;
            default: return t_cmd;
        endcase
    endfunction

    // Stimulus only: optionally raises all dones for one edge (edge 0), then
    // counts edges until command_valid is seen (bounded at 40).
    task automatic wait_decision(input int w, input bit launch, output int lat,
                                 output logic [CW-1:0] cmd, output logic busy1);
        if (launch) begin
            set_done(w, '1);
            tick();
            set_done(w, '0);
        end
        lat   = 0;
        busy1 = 1'b0;
        while (!get_valid(w) && lat < 40) begin
            tick();
            lat++;
            if (lat == 1) busy1 = get_busy(w);
        end
        cmd = get_cmd(w);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (a_train !== 9'h000) begin n_bad++; $display("FAIL reset_train: got %h want 000", a_train); end
        n_cmp++; if (a_cmd !== 4'h0) begin n_bad++; $display("FAIL reset_command: got %h want 0", a_cmd); end
        n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", a_valid); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_cmp++; if (a_terr !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", a_terr); end
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        n_cmp++; if ({a_valid, a_busy, a_terr, m_valid, t_terr} !== 5'b0) begin
            n_bad++; $display("FAIL reset_idle: got %b want 00000", {a_valid, a_busy, a_terr, m_valid, t_terr}); end
    endtask

    task automatic test_basic();
        int lat; logic [CW-1:0] cmd; logic b1;
        basic_scores();
        wait_decision(0, 1'b1, lat, cmd, b1);
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL basic_latency: got %0d want 10", lat); end
        n_cmp++; if (cmd !== 4'd7) begin n_bad++; $display("FAIL basic_command: got %0d want 7", cmd); end
        n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL basic_busy_edge1: got %b want 1", b1); end
        tick();
        n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL basic_single_cycle: got %b want 0", a_valid); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_drop: got %b want 0", a_busy); end
        repeat (2) tick();
    endtask

    task automatic test_noise_and_tie();
        int lat; logic [CW-1:0] cmd; logic b1;
        basic_scores();
        sc[0] = 300; apply_scores();
        wait_decision(0, 1'b1, lat, cmd, b1);
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL noise_latency: got %0d want 10", lat); end
        n_cmp++; if (cmd !== 4'd0) begin n_bad++; $display("FAIL noise_command: got %0d want 0", cmd); end
        repeat (3) tick();
        for (int c = 1; c < NC; c++) sc[c] = 900;
        sc[0] = 1000; sc[2] = 100; sc[5] = 100; apply_scores();
        wait_decision(0, 1'b1, lat, cmd, b1);
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL tie_latency: got %0d want 10", lat); end
        n_cmp++; if (cmd !== 4'd5) begin n_bad++; $display("FAIL tie_command: got %0d want 5", cmd); end
        repeat (3) tick();
    endtask

    task automatic test_margin();
        int lat; logic [CW-1:0] cmd; logic b1;
        int noise_v [4];
        int best_v  [4];
        logic [CW-1:0] exp_v [4];
        noise_v[0] = 1011;      best_v[0] = 960;       exp_v[0] = 4'd6;
        noise_v[1] = 1010;      best_v[1] = 960;       exp_v[1] = 4'd0;
        noise_v[2] = 1000;      best_v[2] = 960;       exp_v[2] = 4'd0;
        noise_v[3] = 134217727; best_v[3] = 134217678; exp_v[3] = 4'd0;
        for (int i = 0; i < 4; i++) begin
            for (int c = 1; c < NC; c++) sc[c] = 134217727;
            sc[0] = noise_v[i];
            sc[3] = best_v[i];
            apply_scores();
            wait_decision(1, 1'b1, lat, cmd, b1);
            n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL margin_latency[%0d]: got %0d want 10", i, lat); end
            n_cmp++; if (cmd !== exp_v[i]) begin n_bad++; $display("FAIL margin_command[%0d]: got %0d want %0d", i, cmd, exp_v[i]); end
            repeat (3) tick();
        end
    endtask

    task automatic test_staggered();
        int lat; logic [CW-1:0] cmd; logic b1;
        int orig [NC];
        basic_scores();
        for (int c = 0; c < NC; c++) orig[c] = sc[c];
        for (int c = 0; c < NC; c++) sc[c] = 0;
        apply_scores();
        // Dones stay high once raised; each score is trashed right after its capture.
        for (int c = 0; c < NC; c++) begin
            sc[c] = orig[c]; apply_scores();
            done_a[c] = 1'b1;
            tick();
            sc[c] = 0; apply_scores();
        end
        done_a = '0;
        wait_decision(0, 1'b0, lat, cmd, b1);
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL stagger_latency: got %0d want 10", lat); end
        n_cmp++; if (cmd !== 4'd7) begin n_bad++; $display("FAIL stagger_command: got %0d want 7", cmd); end
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        int n; int vcount;
        basic_scores();
        done_t = 9'h0FF;
        tick();
        done_t = '0;
        n = 0; vcount = 0;
        while (!t_terr && n < 40) begin
            tick(); n++;
            if (t_valid) vcount++;
        end
        n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL timeout_cycle: got %0d want 16", n); end
        tick();
        n_cmp++; if (t_terr !== 1'b0) begin n_bad++; $display("FAIL timeout_single_cycle: got %b want 0", t_terr); end
        repeat (15) begin
            tick();
            if (t_valid) vcount++;
        end
        n_cmp++; if (vcount !== 0) begin n_bad++; $display("FAIL timeout_no_valid: got %0d strobes want 0", vcount); end
        n_cmp++; if (t_busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy: got %b want 0", t_busy); end
    endtask

    task automatic test_training();
        int lat; logic [CW-1:0] cmd; logic b1; int vcount;
        logic [CW-1:0] sel_v [4];
        logic [NW:0]   exp_v [4];
        sel_v[0] = 4'd0;  exp_v[0] = 9'h001;
        sel_v[1] = 4'd4;  exp_v[1] = 9'h002;
        sel_v[2] = 4'd11; exp_v[2] = 9'h100;
        sel_v[3] = 4'd12; exp_v[3] = 9'h000;
        training_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            training_select = sel_v[i];
            tick();
            n_cmp++; if (a_train !== exp_v[i]) begin n_bad++; $display("FAIL train_decode[%0d]: got %h want %h", i, a_train, exp_v[i]); end
        end
        training_select = 4'd0;
        training_enable = 1'b0;
        tick();
        n_cmp++; if (a_train !== 9'h000) begin n_bad++; $display("FAIL train_off: got %h want 000", a_train); end
        // Abort a round mid-SCAN.
        basic_scores();
        done_a = '1; tick(); done_a = '0;
        repeat (3) tick();
        n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL train_pre_abort_busy: got %b want 1", a_busy); end
        training_enable = 1'b1;
        tick();
        training_enable = 1'b0;
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL train_abort_busy: got %b want 0", a_busy); end
        vcount = 0;
        repeat (20) begin
            tick();
            if (a_valid || a_terr) vcount++;
        end
        n_cmp++; if (vcount !== 0) begin n_bad++; $display("FAIL train_abort_strobe: got %0d strobes want 0", vcount); end
        wait_decision(0, 1'b1, lat, cmd, b1);
        n_cmp++; if (lat !== 10 || cmd !== 4'd7) begin n_bad++; $display("FAIL train_after_round: got lat %0d cmd %0d want 10/7", lat, cmd); end
        repeat (3) tick();
    endtask

    task automatic test_async_reset();
        int lat; logic [CW-1:0] cmd; logic b1; int vcount;
        basic_scores();
        done_a = '1; tick(); done_a = '0;
        repeat (4) tick();
        n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL areset_pre_busy: got %b want 1", a_busy); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({a_busy, a_valid, a_terr} !== 3'b000) begin n_bad++; $display("FAIL areset_ctrl: got %b want 000", {a_busy, a_valid, a_terr}); end
        n_cmp++; if (a_cmd !== 4'd0) begin n_bad++; $display("FAIL areset_command: got %0d want 0", a_cmd); end
        tick();
        #2 reset = 1'b0;
        vcount = 0;
        repeat (20) begin
            tick();
            if (a_valid || a_busy) vcount++;
        end
        n_cmp++; if (vcount !== 0) begin n_bad++; $display("FAIL areset_pending: got %0d active cycles want 0", vcount); end
        wait_decision(0, 1'b1, lat, cmd, b1);
        n_cmp++; if (lat !== 10 || cmd !== 4'd7) begin n_bad++; $display("FAIL areset_fresh_round: got lat %0d cmd %0d want 10/7", lat, cmd); end
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        int lat; logic [CW-1:0] cmd; logic b1;
        basic_scores();
        wait_decision(0, 1'b1, lat, cmd, b1);
        n_cmp++; if (cmd !== 4'd7) begin n_bad++; $display("FAIL b2b_first: got %0d want 7", cmd); end
        // Strobe cycle: the next round's dones are offered immediately.
        for (int c = 1; c < NC; c++) sc[c] = 900;
        sc[0] = 1000; sc[2] = 100; sc[5] = 100; apply_scores();
        wait_decision(0, 1'b1, lat, cmd, b1);
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL b2b_latency: got %0d want 10", lat); end
        n_cmp++; if (cmd !== 4'd5) begin n_bad++; $display("FAIL b2b_command: got %0d want 5", cmd); end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_noise_and_tie();
        test_margin();
        test_staggered();
        test_timeout();
        test_training();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, time limit reached");
        $fatal(1);
    end

endmodule
